// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM state
// encodings, the hard-wired zero register index and a small state helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_IWAIT = 2'd1,
    ST_DWAIT = 2'd2,
    ST_HALT  = 2'd3
  } ctrl_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True while the pipeline is frozen waiting on a memory.
  function automatic logic is_wait(input ctrl_state_e s);
    return (s == ST_IWAIT) || (s == ST_DWAIT);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake/bus bundle between the pipeline sequencing controller (master)
// and the CPU datapath / memories (slave).
interface pipe_ctrl_if #(
  parameter int unsigned PERF_W = 32
);
  // Memory handshakes
  logic              im_ready;
  logic              im_req;
  logic              mem_dm_read;
  logic              mem_dm_write;
  logic              dm_ready;
  // Hazard-relevant stage fields
  logic              ex_dm_read;
  logic [4:0]        ex_write_reg_addr;
  logic [4:0]        id_ra_addr;
  logic [4:0]        id_rt_addr;
  logic              id_uses_rt;
  logic              branch_taken;
  // Debug control
  logic              halt_req;
  logic              resume;
  // Pipeline-register controls and status
  logic              enable_regwalls;
  logic              do_hazard;
  logic              do_flush_REG1;
  logic              pc_write;
  logic [1:0]        ctrl_state;
  logic              bus_error;
  logic [PERF_W-1:0] stall_cnt;
  logic [PERF_W-1:0] hazard_cnt;
  logic [PERF_W-1:0] flush_cnt;

  modport master (
    input  im_ready, mem_dm_read, mem_dm_write, dm_ready,
    input  ex_dm_read, ex_write_reg_addr, id_ra_addr, id_rt_addr, id_uses_rt,
    input  branch_taken, halt_req, resume,
    output im_req, enable_regwalls, do_hazard, do_flush_REG1, pc_write,
    output ctrl_state, bus_error, stall_cnt, hazard_cnt, flush_cnt
  );

  modport slave (
    output im_ready, mem_dm_read, mem_dm_write, dm_ready,
    output ex_dm_read, ex_write_reg_addr, id_ra_addr, id_rt_addr, id_uses_rt,
    output branch_taken, halt_req, resume,
    input  im_req, enable_regwalls, do_hazard, do_flush_REG1, pc_write,
    input  ctrl_state, bus_error, stall_cnt, hazard_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_detect.sv
// Load-use hazard compare between the EX-stage load destination and the
// ID-stage sources. Purely combinational; state gating is done by the caller.
module pipe_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       i_ex_dm_read,
  input  logic [4:0] i_ex_write_reg_addr,
  input  logic [4:0] i_id_ra_addr,
  input  logic [4:0] i_id_rt_addr,
  input  logic       i_id_uses_rt,
  output logic       o_hazard
);

  logic w_ra_match;
  logic w_rt_match;

  // r0 is hard-wired to zero, so a load targeting it never creates a dependency.
  always_comb begin
    w_ra_match = (i_ex_write_reg_addr == i_id_ra_addr);
    w_rt_match = i_id_uses_rt && (i_ex_write_reg_addr == i_id_rt_addr);
    o_hazard   = i_ex_dm_read && (i_ex_write_reg_addr != REG_ZERO) && (w_ra_match || w_rt_match);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage CPU: global advance enable,
// load-use bubble, IF/ID flush, memory-wait stall with watchdog, debug halt.
// State updates on the falling clock edge, matching the pipeline registers.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_W      = 8,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned PERF_W      = 32
) (
  input  logic        clock,
  input  logic        reset,
  pipe_ctrl_if.master bus
);

  ctrl_state_e       r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_bus_error;

  logic w_not_halt;
  logic w_dm_busy;
  logic w_go;
  logic w_hazard_raw;
  logic w_hazard;
  logic w_flush;
  logic w_timeout;

  pipe_hazard_detect u_hazard (
    .i_ex_dm_read       (bus.ex_dm_read),
    .i_ex_write_reg_addr(bus.ex_write_reg_addr),
    .i_id_ra_addr       (bus.id_ra_addr),
    .i_id_rt_addr       (bus.id_rt_addr),
    .i_id_uses_rt       (bus.id_uses_rt),
    .o_hazard           (w_hazard_raw)
  );

  // Advance / hazard / flush decode; hazard wins over a branch flush so the
  // branch re-resolves after the bubble.
  always_comb begin
    w_not_halt = (r_state != ST_HALT);
    w_dm_busy  = (bus.mem_dm_read || bus.mem_dm_write) && !bus.dm_ready;
    w_go       = w_not_halt && bus.im_ready && !w_dm_busy;
    w_hazard   = w_hazard_raw && w_not_halt;
    w_flush    = bus.branch_taken && !w_hazard && w_not_halt;
    w_timeout  = (r_wait_cnt == WAIT_W'(MEM_TIMEOUT));
  end

  // Outputs held at their idle values while reset is asserted.
  always_comb begin
    bus.enable_regwalls = !reset && w_go;
    bus.do_hazard       = !reset && w_hazard;
    bus.do_flush_REG1   = !reset && w_flush;
    bus.pc_write        = !reset && w_go && !w_hazard;
    bus.im_req          = reset || w_not_halt;
    bus.ctrl_state      = reset ? ST_RUN : r_state;
    bus.bus_error       = r_bus_error;
  end

  // Sequencing FSM with memory-wait watchdog; bus_error is sticky until reset.
  always_ff @(negedge clock) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= '0;
      r_bus_error <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_wait_cnt <= '0;
          if (bus.halt_req && w_go) begin
            r_state <= ST_HALT;
          end else if (w_dm_busy) begin
            r_state <= ST_DWAIT;
          end else if (!bus.im_ready) begin
            r_state <= ST_IWAIT;
          end
        end
        ST_IWAIT, ST_DWAIT: begin
          // Counter keeps running across IWAIT<->DWAIT re-targets.
          r_wait_cnt <= r_wait_cnt + 1'b1;
          if (w_go) begin
            r_state <= bus.halt_req ? ST_HALT : ST_RUN;
          end else if (w_timeout) begin
            r_bus_error <= 1'b1;
            r_state     <= ST_HALT;
          end else begin
            r_state <= w_dm_busy ? ST_DWAIT : ST_IWAIT;
          end
        end
        ST_HALT: begin
          r_wait_cnt <= '0;
          if (bus.resume && !bus.halt_req && !r_bus_error) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state    <= ST_RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  logic [PERF_W-1:0] r_stall_cnt;
  logic [PERF_W-1:0] r_hazard_cnt;
  logic [PERF_W-1:0] r_flush_cnt;

  // Saturating event counters; all frozen while halted.
  always_ff @(negedge clock) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_hazard_cnt <= '0;
      r_flush_cnt  <= '0;
    end else if (w_not_halt) begin
      if (is_wait(r_state) && (r_stall_cnt != PERF_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_hazard && w_go && (r_hazard_cnt != PERF_MAX)) begin
        r_hazard_cnt <= r_hazard_cnt + 1'b1;
      end
      if (w_flush && w_go && (r_flush_cnt != PERF_MAX)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign bus.stall_cnt  = r_stall_cnt;
  assign bus.hazard_cnt = r_hazard_cnt;
  assign bus.flush_cnt  = r_flush_cnt;
`else
  assign bus.stall_cnt  = {PERF_W{1'b0}};
  assign bus.hazard_cnt = {PERF_W{1'b0}};
  assign bus.flush_cnt  = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the stimulus process drives one directed
// vector per cycle (just after the falling edge) and queues the hand-computed
// outputs; the monitor pops and compares on the following rising edge.
module tb_pipe_ctrl;

  localparam int unsigned PERF_W = 32;
  localparam int unsigned T      = 255;

  typedef struct {
    int          id;
    logic        en;
    logic        haz;
    logic        fl;
    logic        pcw;
    logic        imq;
    logic [1:0]  st;
    logic        be;
    bit          pchk;
    logic [31:0] sc;
    logic [31:0] hc;
    logic [31:0] fc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   vec_id   = 0;
  exp_t exp_q[$];

  pipe_ctrl_if #(.PERF_W(PERF_W)) bus ();

  pipe_ctrl #(
    .WAIT_W     (8),
    .MEM_TIMEOUT(T),
    .PERF_W     (PERF_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Expected perf counter value: zero whenever the counters are not built.
  function automatic logic [31:0] pv(input int v);
`ifdef PIPE_PERF_CNT_EN
    return 32'(v);
`else
    return 32'd0 + 32'(v - v);
`endif
  endfunction

  task automatic idle_inputs();
    bus.im_ready          = 1'b1;
    bus.mem_dm_read       = 1'b0;
    bus.mem_dm_write      = 1'b0;
    bus.dm_ready          = 1'b1;
    bus.ex_dm_read        = 1'b0;
    bus.ex_write_reg_addr = 5'd0;
    bus.id_ra_addr        = 5'd0;
    bus.id_rt_addr        = 5'd0;
    bus.id_uses_rt        = 1'b0;
    bus.branch_taken      = 1'b0;
    bus.halt_req          = 1'b0;
    bus.resume            = 1'b0;
  endtask

  // Move to the next cycle: just after the falling (state-update) edge.
  task automatic step();
    @(negedge clock);
    #1;
    idle_inputs();
  endtask

  task automatic exp_full(input logic en, haz, fl, pcw, imq, input logic [1:0] st,
                          input logic be, input bit pchk, input logic [31:0] sc, hc, fc);
    exp_t e;
    e.id = vec_id; e.en = en; e.haz = haz; e.fl = fl; e.pcw = pcw; e.imq = imq;
    e.st = st; e.be = be; e.pchk = pchk; e.sc = sc; e.hc = hc; e.fc = fc;
    exp_q.push_back(e);
    vec_id++;
  endtask

  task automatic exp_out(input logic en, haz, fl, pcw, imq, input logic [1:0] st,
                         input logic be);
    exp_full(en, haz, fl, pcw, imq, st, be, 1'b0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic chk(input int id, input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL vec%0d %s: got %0h, expected %0h", id, nm, act, expv);
    end
  endtask

  // Monitor: compare the queued expectation against the DUT mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.id, "enable_regwalls", 32'(bus.enable_regwalls), 32'(e.en));
        chk(e.id, "do_hazard", 32'(bus.do_hazard), 32'(e.haz));
        chk(e.id, "do_flush_REG1", 32'(bus.do_flush_REG1), 32'(e.fl));
        chk(e.id, "pc_write", 32'(bus.pc_write), 32'(e.pcw));
        chk(e.id, "im_req", 32'(bus.im_req), 32'(e.imq));
        chk(e.id, "ctrl_state", 32'(bus.ctrl_state), 32'(e.st));
        chk(e.id, "bus_error", 32'(bus.bus_error), 32'(e.be));
        if (e.pchk) begin
          chk(e.id, "stall_cnt", bus.stall_cnt, e.sc);
          chk(e.id, "hazard_cnt", bus.hazard_cnt, e.hc);
          chk(e.id, "flush_cnt", bus.flush_cnt, e.fc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    // vec0: reset held; hazard/branch inputs must be masked
    step();
    bus.ex_dm_read = 1; bus.ex_write_reg_addr = 5'd3; bus.id_ra_addr = 5'd3;
    bus.branch_taken = 1;
    exp_out(0, 0, 0, 0, 1, 2'd0, 0);

    // vec1: out of reset, idle
    step(); reset = 1'b0;
    exp_full(1, 0, 0, 1, 1, 2'd0, 0, 1, pv(0), pv(0), pv(0));
    // vec2: load r3 in EX, ID reads ra=r3
    step(); bus.ex_dm_read = 1; bus.ex_write_reg_addr = 5'd3; bus.id_ra_addr = 5'd3;
    exp_out(1, 1, 0, 0, 1, 2'd0, 0);
    // vec3: load to r0 never hazards
    step(); bus.ex_dm_read = 1; bus.ex_write_reg_addr = 5'd0; bus.id_ra_addr = 5'd0;
    exp_out(1, 0, 0, 1, 1, 2'd0, 0);
    // vec4: rt match with uses_rt
    step(); bus.ex_dm_read = 1; bus.ex_write_reg_addr = 5'd5; bus.id_rt_addr = 5'd5;
    bus.id_ra_addr = 5'd1; bus.id_uses_rt = 1;
    exp_out(1, 1, 0, 0, 1, 2'd0, 0);
    // vec5: rt match ignored without uses_rt
    step(); bus.ex_dm_read = 1; bus.ex_write_reg_addr = 5'd5; bus.id_rt_addr = 5'd5;
    bus.id_ra_addr = 5'd1;
    exp_out(1, 0, 0, 1, 1, 2'd0, 0);
    // vec6: branch, no hazard -> flush
    step(); bus.branch_taken = 1;
    exp_out(1, 0, 1, 1, 1, 2'd0, 0);
    // vec7: branch with hazard -> hazard wins
    step(); bus.branch_taken = 1; bus.ex_dm_read = 1; bus.ex_write_reg_addr = 5'd7;
    bus.id_ra_addr = 5'd7;
    exp_out(1, 1, 0, 0, 1, 2'd0, 0);
    // vec8: idle; three hazard cycles and one flush cycle so far
    step();
    exp_full(1, 0, 0, 1, 1, 2'd0, 0, 1, pv(0), pv(3), pv(1));

    // vec9-12: store waiting on DM for four cycles
    step(); bus.mem_dm_write = 1; bus.dm_ready = 0;
    exp_out(0, 0, 0, 0, 1, 2'd0, 0);
    for (int i = 0; i < 3; i++) begin
      step(); bus.mem_dm_write = 1; bus.dm_ready = 0;
      exp_out(0, 0, 0, 0, 1, 2'd2, 0);
    end
    // vec13: DM completes, advance from DWAIT
    step(); bus.mem_dm_write = 1; bus.dm_ready = 1;
    exp_out(1, 0, 0, 1, 1, 2'd2, 0);
    // vec14: back in RUN, four stall cycles counted
    step();
    exp_full(1, 0, 0, 1, 1, 2'd0, 0, 1, pv(4), pv(3), pv(1));

    // vec15: halt request in RUN, current advance completes
    step(); bus.halt_req = 1;
    exp_out(1, 0, 0, 1, 1, 2'd0, 0);
    // vec16: halted; hazard and branch masked
    step(); bus.halt_req = 1; bus.ex_dm_read = 1; bus.ex_write_reg_addr = 5'd3;
    bus.id_ra_addr = 5'd3; bus.branch_taken = 1;
    exp_out(0, 0, 0, 0, 0, 2'd3, 0);
    // vec17: resume while halt_req high is ignored
    step(); bus.halt_req = 1; bus.resume = 1;
    exp_out(0, 0, 0, 0, 0, 2'd3, 0);
    // vec18: still halted
    step();
    exp_out(0, 0, 0, 0, 0, 2'd3, 0);
    // vec19: resume pulse
    step(); bus.resume = 1;
    exp_out(0, 0, 0, 0, 0, 2'd3, 0);
    // vec20: running again; counters frozen across HALT
    step();
    exp_full(1, 0, 0, 1, 1, 2'd0, 0, 1, pv(4), pv(3), pv(1));

    // vec21: IM not ready in RUN
    step(); bus.im_ready = 0;
    exp_out(0, 0, 0, 0, 1, 2'd0, 0);
    // vec22: IWAIT, DM also goes busy
    step(); bus.im_ready = 0; bus.mem_dm_read = 1; bus.dm_ready = 0;
    exp_out(0, 0, 0, 0, 1, 2'd1, 0);
    // vec23: re-targeted to DWAIT
    step(); bus.im_ready = 0; bus.mem_dm_read = 1; bus.dm_ready = 0;
    exp_out(0, 0, 0, 0, 1, 2'd2, 0);
    // vec24: DM done, IM still not ready
    step(); bus.im_ready = 0;
    exp_out(0, 0, 0, 0, 1, 2'd2, 0);
    // vec25: IWAIT, go with halt_req -> HALT
    step(); bus.halt_req = 1;
    exp_out(1, 0, 0, 1, 1, 2'd1, 0);
    // vec26: halted
    step(); bus.halt_req = 1;
    exp_out(0, 0, 0, 0, 0, 2'd3, 0);
    // vec27: resume
    step(); bus.resume = 1;
    exp_out(0, 0, 0, 0, 0, 2'd3, 0);
    // vec28: running; stall cycles 22..25 added
    step();
    exp_full(1, 0, 0, 1, 1, 2'd0, 0, 1, pv(8), pv(3), pv(1));

    // vec29-30: enter DWAIT
    step(); bus.mem_dm_read = 1; bus.dm_ready = 0;
    exp_out(0, 0, 0, 0, 1, 2'd0, 0);
    step(); bus.mem_dm_read = 1; bus.dm_ready = 0;
    exp_out(0, 0, 0, 0, 1, 2'd2, 0);
    // vec31: reset asserted mid-wait -> outputs at reset values
    step(); reset = 1'b1; bus.mem_dm_read = 1; bus.dm_ready = 0;
    bus.ex_dm_read = 1; bus.ex_write_reg_addr = 5'd4; bus.id_ra_addr = 5'd4;
    bus.branch_taken = 1;
    exp_out(0, 0, 0, 0, 1, 2'd0, 0);
    // vec32: back in RUN, counters cleared
    step(); reset = 1'b0; bus.mem_dm_read = 1; bus.dm_ready = 0;
    exp_full(0, 0, 0, 0, 1, 2'd0, 0, 1, pv(0), pv(0), pv(0));
    // vec33: DWAIT restarted, DM now ready
    step();
    exp_out(1, 0, 0, 1, 1, 2'd2, 0);
    // vec34: RUN
    step();
    exp_out(1, 0, 0, 1, 1, 2'd0, 0);

    // Watchdog: IM never ready
    step(); bus.im_ready = 0;
    exp_out(0, 0, 0, 0, 1, 2'd0, 0);
    for (int k = 1; k <= int'(T) + 1; k++) begin
      step(); bus.im_ready = 0;
      if (k == int'(T)) exp_out(0, 0, 0, 0, 1, 2'd1, 0);
    end
    // Timed out: HALT with sticky bus_error
    step();
    exp_out(0, 0, 0, 0, 0, 2'd3, 1);
    // Resume cannot leave an error HALT
    step(); bus.resume = 1;
    exp_out(0, 0, 0, 0, 0, 2'd3, 1);
    step();
    exp_out(0, 0, 0, 0, 0, 2'd3, 1);
    // Reset clears the error
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    exp_full(1, 0, 0, 1, 1, 2'd0, 0, 1, pv(0), pv(0), pv(0));

    step();
    step();
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencing controller for the 5-stage CPU. It drives the pipeline-register control inputs: global advance enable, load-use hazard bubble and IF/ID flush. It stalls the whole pipeline while instruction or data memory is not ready, with a watchdog timeout. It also provides halt/resume control for debug. It sits beside the pipeline-register block in the CPU top and consumes hazard-relevant fields from the ID, EX and MEM stages.

Parameters:
WAIT_W, 8, width of the memory-wait watchdog counter
MEM_TIMEOUT, 255, number of consecutive wait cycles before bus error (must be < 2**WAIT_W)
PERF_W, 32, width of the optional performance counters

Ports:
clock  in  1  system clock; all state updates on falling edge, the same edge as the pipeline registers
reset  in  1  synchronous, active-high
im_ready  in  1  instruction memory has valid data this cycle
im_req  out  1  instruction fetch request
mem_dm_read  in  1  MEM-stage load (pipeline-register stage-3 dm_read)
mem_dm_write  in  1  MEM-stage store
dm_ready  in  1  data memory completes the access this cycle
ex_dm_read  in  1  EX-stage instruction is a load (stage-2 dm_read)
ex_write_reg_addr  in  5  EX-stage destination register
id_ra_addr  in  5  ID-stage source register ra
id_rt_addr  in  5  ID-stage source register rt
id_uses_rt  in  1  ID instruction reads rt
branch_taken  in  1  ID-stage branch/jump redirect
halt_req  in  1  debug halt request (level)
resume  in  1  debug resume pulse
enable_regwalls  out  1  advance all pipeline registers
do_hazard  out  1  hold IF/ID, bubble ID/EX
do_flush_REG1  out  1  zero IF/ID
pc_write  out  1  PC update enable
ctrl_state  out  2  0 RUN, 1 IWAIT, 2 DWAIT, 3 HALT
bus_error  out  1  sticky watchdog error
stall_cnt, hazard_cnt, flush_cnt  out  PERF_W each  performance counters (optional feature)

Behaviour:
- Reset: state RUN, wait counter 0, bus_error 0, all counters 0.
- Definitions: dm_busy = (mem_dm_read | mem_dm_write) & ~dm_ready. go = (state != HALT) & im_ready & ~dm_busy.
- Combinational outputs:
  - enable_regwalls = go.
  - im_req = (state != HALT).
  - Reset outputs: enable_regwalls 0, do_hazard 0, do_flush_REG1 0, pc_write 0, im_req 1, ctrl_state 0.
- do_hazard:
  - Asserted when ex_dm_read & (ex_write_reg_addr != 0) & ((ex_write_reg_addr == id_ra_addr) | (id_uses_rt & ex_write_reg_addr == id_rt_addr)) & (state != HALT).
  - Register 0 never produces a hazard.
- do_flush_REG1 = branch_taken & ~do_hazard & (state != HALT). Hazard has priority; the branch re-resolves after the bubble.
- pc_write = go & ~do_hazard.
- State transitions (evaluated each edge):
  - RUN:
    - halt_req & go -> HALT; the current advance still completes.
    - else dm_busy -> DWAIT; DM has priority over IM.
    - else ~im_ready -> IWAIT.
  - IWAIT / DWAIT:
    - go -> RUN, or HALT if halt_req.
    - else if dm_busy -> DWAIT, else IWAIT; re-targets as conditions change without resetting the counter.
  - HALT:
    - resume & ~halt_req & ~bus_error -> RUN.
    - Otherwise stay. A resume pulse while halt_req is high is ignored.
- Watchdog:
  - Counter clears in RUN/HALT and increments in IWAIT/DWAIT.
  - When the counter equals MEM_TIMEOUT and the stall persists: bus_error <= 1, state -> HALT.
  - bus_error clears only on reset, so HALT with bus_error is exited only by reset.
- Reset mid-wait: returns to RUN immediately, counter cleared; the memory handshake is restarted by the pipeline.

Optional Feature:
PIPE_PERF_CNT_EN:
- Defined: stall_cnt increments each cycle state is IWAIT or DWAIT; hazard_cnt on each cycle do_hazard & go; flush_cnt on each cycle do_flush_REG1 & go. All saturate at 2**PERF_W-1, reset to 0, and freeze in HALT.
- Undefined: the three outputs are tied to 0 and no counter flops exist.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encodings: ST_RUN=2'd0, ST_IWAIT=2'd1, ST_DWAIT=2'd2, ST_HALT=2'd3
  - REG_ZERO=5'd0
- Sub-module pipe_hazard_detect: purely combinational load-use compare, producing do_hazard before state gating.

Test Plan:
- Load r3 in EX (ex_dm_read=1, ex_write_reg_addr=3), ID reads ra=3 -> do_hazard=1, pc_write=0, enable_regwalls=1; same with addr 0 -> do_hazard=0.
- branch_taken=1 with no hazard -> do_flush_REG1=1 one cycle. With a simultaneous hazard -> flush=0, hazard=1.
- mem_dm_write=1, dm_ready=0 for 4 cycles -> ctrl_state=2, enable_regwalls=0 for 4 cycles, RUN on the cycle dm_ready=1. With PIPE_PERF_CNT_EN, stall_cnt=4.
- im_ready=0 for MEM_TIMEOUT+1 cycles -> bus_error=1, ctrl_state=3, im_req=0. A resume pulse does not leave HALT; reset clears everything.
- halt_req=1 in RUN -> HALT after one advance. Drop halt_req, pulse resume -> RUN next edge.
- Assert reset during DWAIT -> next edge ctrl_state=0, counter 0, outputs at reset values.
